uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 8 +
 rtl/uart_rx_sampler.sv | 32 +++
 rtl/uart_rx.sv | 86 ++++++++
 tb/tb_uart_rx.sv | 119 +++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM state type and UART receiver constants
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam logic [5:0] PRESCALE_8 = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;
  localparam int DEFAULT_DATA_WIDTH = 8;
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter and 3-point majority vote around bit centre
module uart_rx_sampler (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en_i,
  input  logic       rx_i,
  input  logic [5:0] prescale_i,
  output logic       wrap_o,
  output logic       done_o,
  output logic       bit_o
);
  logic [5:0] cnt_q, cnt_d, half;
  logic [2:0] smp_q;
  assign half = {1'b0, prescale_i[5:1]};
  assign wrap_o = cnt_q >= prescale_i - 6'd1;
  assign done_o = cnt_q == half + 6'd2;
  assign bit_o = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
  // Counter clears when idle/aborting and wraps at the bit boundary; >= keeps it bounded if Prescale shrinks mid-frame
  always_comb cnt_d = !en_i ? '0 : wrap_o ? '0 : cnt_q + 6'd1;
  // Capture the line at the three centre edges of the current bit
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      smp_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (cnt_q == half - 6'd1) smp_q[0] <= rx_i;
      if (cnt_q == half) smp_q[1] <= rx_i;
      if (cnt_q == half + 6'd1) smp_q[2] <= rx_i;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with optional parity and stop-bit checking
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  state_e state_q;
  logic [CW-1:0] bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic par_bad_q, wrap, done, smp, abort, en;
  assign abort = done && (state_q == STOP || (state_q == START && smp));
  assign en = (state_q == IDLE) ? !RX_IN : !abort;
  uart_rx_sampler u_sampler (
    .CLK       (CLK),
    .RST       (RST),
    .en_i      (en),
    .rx_i      (RX_IN),
    .prescale_i(Prescale),
    .wrap_o    (wrap),
    .done_o    (done),
    .bit_o     (smp)
  );
  // Frame FSM: shifts data, checks parity and stop bit, emits one-cycle result pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      shift_q <= '0;
      par_bad_q <= 1'b0;
      P_DATA <= '0;
      data_valid <= 1'b0;
      par_err <= 1'b0;
      stp_err <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err <= 1'b0;
      stp_err <= 1'b0;
      case (state_q)
        IDLE: if (!RX_IN) begin
          state_q <= START;
          par_bad_q <= 1'b0;
        end
        START: if (done && smp) state_q <= IDLE;
        else if (wrap) begin
          state_q <= DATA;
          bit_cnt_q <= '0;
        end
        DATA: begin
          if (done) shift_q <= {smp, shift_q[DATA_WIDTH-1:1]};
          if (wrap) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == CW'(DATA_WIDTH - 1)) state_q <= PAR_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (done && (smp != (^shift_q ^ PAR_TYP))) begin
            par_bad_q <= 1'b1;
            par_err <= 1'b1;
          end
          if (wrap) state_q <= STOP;
        end
        STOP: if (done) begin
          state_q <= IDLE;
          if (!smp) stp_err <= 1'b1;
          else if (!par_bad_q) begin
            P_DATA <= shift_q;
            data_valid <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frame vectors plus directed glitch, reset and back-to-back sequences
module tb_uart_rx;
  logic CLK = 1'b0, RST = 1'b1, RX_IN = 1'b1, PAR_EN = 1'b0, PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd16;
  logic [7:0] P_DATA;
  logic data_valid, par_err, stp_err;
  int checks = 0, errors = 0;
  int n_dv = 0, n_pe = 0, n_se = 0;
  typedef struct {
    int p; bit pe; bit pt; logic [7:0] d; bit pb; bit sb;
    int dv; int perr; int serr; logic [7:0] pd;
  } vec_t;
  vec_t v[16];
  uart_rx dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (data_valid) n_dv++;
    if (par_err) n_pe++;
    if (stp_err) n_se++;
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive_bit(input bit b, input int p);
    RX_IN = b;
    repeat (p) @(negedge CLK);
  endtask
  task automatic send_frame(input logic [7:0] d, input bit pe, input bit pb, input bit sb, input int p);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pe) drive_bit(pb, p);
    drive_bit(sb, p);
    RX_IN = 1'b1;
  endtask
  task automatic cfg(input int p, input bit pe, input bit pt);
    Prescale = 6'(p);
    PAR_EN = pe;
    PAR_TYP = pt;
  endtask
  initial begin
    int dv0, pe0, se0;
    v[0]  = '{32, 1, 1, 8'hBB, 1, 1, 1, 0, 0, 8'hBB};
    v[1]  = '{8,  1, 0, 8'hBB, 0, 1, 1, 0, 0, 8'hBB};
    v[2]  = '{8,  1, 1, 8'hBB, 1, 1, 1, 0, 0, 8'hBB};
    v[3]  = '{8,  0, 0, 8'hBB, 0, 1, 1, 0, 0, 8'hBB};
    v[4]  = '{16, 1, 0, 8'hBB, 0, 1, 1, 0, 0, 8'hBB};
    v[5]  = '{16, 1, 1, 8'hBB, 1, 1, 1, 0, 0, 8'hBB};
    v[6]  = '{16, 0, 0, 8'hBB, 0, 1, 1, 0, 0, 8'hBB};
    v[7]  = '{32, 1, 0, 8'hBB, 0, 1, 1, 0, 0, 8'hBB};
    v[8]  = '{32, 1, 1, 8'hBB, 1, 1, 1, 0, 0, 8'hBB};
    v[9]  = '{32, 0, 0, 8'hBB, 0, 1, 1, 0, 0, 8'hBB};
    v[10] = '{16, 1, 0, 8'h3C, 0, 1, 1, 0, 0, 8'h3C};
    v[11] = '{16, 1, 0, 8'hBB, 1, 1, 0, 1, 0, 8'h3C};
    v[12] = '{16, 0, 0, 8'h5A, 0, 0, 0, 0, 1, 8'h3C};
    v[13] = '{8,  1, 1, 8'h01, 0, 1, 1, 0, 0, 8'h01};
    v[14] = '{32, 1, 1, 8'hFF, 0, 1, 0, 1, 0, 8'h01};
    v[15] = '{8,  0, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00};
    repeat (3) @(negedge CLK);
    chk("reset P_DATA", int'(P_DATA), 0);
    chk("reset data_valid", int'(data_valid), 0);
    chk("reset par_err", int'(par_err), 0);
    chk("reset stp_err", int'(stp_err), 0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    cfg(16, 0, 0);
    dv0 = n_dv; pe0 = n_pe; se0 = n_se;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 40);
    chk("glitch no pulses", (n_dv - dv0) + (n_pe - pe0) + (n_se - se0), 0);
    chk("glitch P_DATA", int'(P_DATA), 0);
    send_frame(8'h3C, 0, 0, 1, 16);
    repeat (32) @(negedge CLK);
    chk("after glitch dv", n_dv - dv0, 1);
    chk("after glitch P_DATA", int'(P_DATA), 8'h3C);
    for (int i = 0; i < 16; i++) begin
      cfg(v[i].p, v[i].pe, v[i].pt);
      dv0 = n_dv; pe0 = n_pe; se0 = n_se;
      send_frame(v[i].d, v[i].pe, v[i].pb, v[i].sb, v[i].p);
      repeat (2 * v[i].p) @(negedge CLK);
      chk($sformatf("vec%0d data_valid", i), n_dv - dv0, v[i].dv);
      chk($sformatf("vec%0d par_err", i), n_pe - pe0, v[i].perr);
      chk($sformatf("vec%0d stp_err", i), n_se - se0, v[i].serr);
      chk($sformatf("vec%0d P_DATA", i), int'(P_DATA), int'(v[i].pd));
    end
    cfg(16, 0, 0);
    dv0 = n_dv; pe0 = n_pe; se0 = n_se;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(i[0], 16);
    drive_bit(1'b1, 8);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("midreset P_DATA", int'(P_DATA), 0);
    chk("midreset pulses", int'({data_valid, par_err, stp_err}), 0);
    RST = 1'b0;
    drive_bit(1'b1, 40);
    chk("midreset no pulses", (n_dv - dv0) + (n_pe - pe0) + (n_se - se0), 0);
    send_frame(8'hA5, 0, 0, 1, 16);
    repeat (32) @(negedge CLK);
    chk("after reset dv", n_dv - dv0, 1);
    chk("after reset P_DATA", int'(P_DATA), 8'hA5);
    cfg(8, 1, 0);
    dv0 = n_dv; pe0 = n_pe; se0 = n_se;
    send_frame(8'h12, 1, 0, 1, 8);
    send_frame(8'h34, 1, 1, 1, 8);
    repeat (16) @(negedge CLK);
    chk("b2b dv", n_dv - dv0, 2);
    chk("b2b errors", (n_pe - pe0) + (n_se - se0), 0);
    chk("b2b P_DATA", int'(P_DATA), 8'h34);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
